// File: rtl/lfsr_stream_xor.sv
// Seeds a downstream LFSR, steps it through a fixed warm-up, then XORs a byte stream with its output.
// Optional running checksum of emitted bytes is enabled by defining LFSR_STREAM_XOR_CKSUM_EN.
module lfsr_stream_xor #(
  parameter int WARMUP = 8,
  parameter int LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_byte,
  input  logic             out_ready,
  input  logic [7:0]       psr_byte,
  output logic             ld_lfsr,
  output logic [31:0]      ld_val,
  output logic             step_lfsr,
  output logic             busy,
  output logic             done,
  output logic [7:0]       cksum
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WARM, S_RUN, S_DONE} state_t;

  localparam logic [7:0] WARM_INIT = 8'(WARMUP);

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_seed;
  logic [LEN_W-1:0] r_remaining;
  logic [7:0]       r_warm_cnt;
  logic             r_out_valid;
  logic [7:0]       r_out_byte;
  logic             w_start_acc;
  logic             w_accept;
  logic             w_drain;
  logic             w_in_ready;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_drain     = r_out_valid && out_ready;
  assign w_in_ready  = (r_state == S_RUN) && (r_remaining != '0) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign ld_val    = r_seed;

  always_comb begin
    w_state_next = r_state;
    ld_lfsr      = 1'b0;
    step_lfsr    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        ld_lfsr      = 1'b1;
        w_state_next = (WARM_INIT != 8'd0) ? S_WARM : S_RUN;
      end
      S_WARM: begin
        step_lfsr = 1'b1;
        if (r_warm_cnt <= 8'd1) w_state_next = S_RUN;
      end
      S_RUN: begin
        // The LFSR advances only when a byte is consumed, so keystream stays aligned with data.
        step_lfsr = w_accept;
        if ((r_remaining == '0) && (!r_out_valid || out_ready)) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_seed      <= 32'h0;
      r_remaining <= '0;
      r_warm_cnt  <= 8'h0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h0;
    end else begin
      r_state <= w_state_next;
      if (w_start_acc) begin
        r_seed      <= seed;
        r_remaining <= msg_len;
        r_warm_cnt  <= WARM_INIT;
      end
      if (r_state == S_WARM) r_warm_cnt <= r_warm_cnt - 8'd1;
      if (w_accept) begin
        r_out_byte  <= in_byte ^ psr_byte;
        r_out_valid <= 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef LFSR_STREAM_XOR_CKSUM_EN
  logic [7:0] r_cksum;

  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_cksum <= 8'h0;
    end else if (w_drain) begin
      r_cksum <= r_cksum ^ r_out_byte;
    end
  end

  assign cksum = r_cksum;
`else
  assign cksum = 8'h00;
`endif

endmodule

// File: tb/tb_lfsr_stream_xor.sv
// Self-checking bench for lfsr_stream_xor: drives an LFSR stand-in and compares the stream to a keystream model.
module tb_lfsr_stream_xor;
  localparam int WARMUP = 8;
  localparam int LEN_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      seed = 32'h0;
  logic [LEN_W-1:0] msg_len = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_byte = 8'h0;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_byte;
  logic             out_ready = 1'b0;
  logic [7:0]       psr_byte;
  logic             ld_lfsr;
  logic [31:0]      ld_val;
  logic             step_lfsr;
  logic             busy;
  logic             done;
  logic [7:0]       cksum;

  always #5 clk = ~clk;

  lfsr_stream_xor #(.WARMUP(WARMUP), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .msg_len(msg_len),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
    .psr_byte(psr_byte), .ld_lfsr(ld_lfsr), .ld_val(ld_val), .step_lfsr(step_lfsr),
    .busy(busy), .done(done), .cksum(cksum)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // LFSR stand-in: a real Galois LFSR, or a fixed table of bytes indexed by post-warm-up step.
  logic [31:0] env_lfsr = 32'h0;
  int          env_steps = 0;
  int          ld_total = 0;
  bit          tbl_mode = 1'b0;
  logic [7:0]  tbl [4];

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [7:0] key_byte(input logic [31:0] s, input int n);
    logic [31:0] st = s;
    for (int k = 0; k < n; k++) st = lfsr_next(st);
    return st[7:0];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_lfsr) begin
      env_lfsr  <= ld_val;
      env_steps <= 0;
      ld_total  <= ld_total + 1;
    end else if (step_lfsr) begin
      env_lfsr  <= lfsr_next(env_lfsr);
      env_steps <= env_steps + 1;
    end
  end

  always_comb begin
    psr_byte = env_lfsr[7:0];
    if (tbl_mode) begin
      if (env_steps >= WARMUP && env_steps < WARMUP + 4) psr_byte = tbl[env_steps - WARMUP];
      else psr_byte = 8'h00;
    end
  end

  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  int first_out_cyc;
  int last_out_cyc;
  int done_cyc;
  bit saw_in_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 always ready, 1 random ready/valid, 2 ready low for 5 cycles after the first output.
  task automatic run_msg(input logic [31:0] s, input int len, input int rmode, input bit inject,
                         output logic [7:0] ck_at_done);
    int idx = 0;
    int bp_left = 0;
    bit bp_started = 1'b0;
    bit hold_pend = 1'b0;
    bit got_done = 1'b0;
    logic [7:0] held = 8'h0;
    int ld_before = ld_total;
    out_q.delete();
    first_out_cyc = -1;
    last_out_cyc  = -1;
    done_cyc      = -1;
    saw_in_ready  = 1'b0;
    ck_at_done    = 8'h0;
    seed = s; msg_len = LEN_W'(len); start = 1'b1;
    tick();
    start = 1'b0; seed = ~s; msg_len = '1;
    #1;
    chk("load_ld", {31'b0, ld_lfsr}, 32'd1);
    chk("load_val", ld_val, s);
    chk("load_step", {31'b0, step_lfsr}, 32'd0);
    for (int w = 0; w < WARMUP; w++) begin
      tick();
      if (inject && w == 3) begin start = 1'b1; seed = 32'h12345678; msg_len = 8'd77; end
      else start = 1'b0;
      #1;
      chk("warm_step", {31'b0, step_lfsr}, 32'd1);
      chk("warm_ld", {31'b0, ld_lfsr}, 32'd0);
      chk("warm_rdy", {31'b0, in_ready}, 32'd0);
    end
    for (int b = 0; b < 2000; b++) begin
      tick();
      start = 1'b0;
      in_valid = (idx < len) && (rmode != 1 || $urandom_range(0, 3) != 0);
      in_byte  = (idx < len) ? in_q[idx] : 8'h00;
      if (rmode == 2 && !bp_started && out_valid) begin bp_started = 1'b1; bp_left = 5; end
      if (rmode == 0) out_ready = 1'b1;
      else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (bp_left == 0);
      if (bp_left > 0) bp_left--;
      #1;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        ck_at_done = cksum;
        chk("done_busy", {31'b0, busy}, 32'd1);
        chk("done_ov", {31'b0, out_valid}, 32'd0);
        if (inject) begin start = 1'b1; seed = 32'hCAFEF00D; msg_len = 8'd3; end
        break;
      end
      chk("run_ld", {31'b0, ld_lfsr}, 32'd0);
      chk("run_step", {31'b0, step_lfsr}, {31'b0, in_valid & in_ready});
      if (hold_pend) begin
        chk("hold_byte", {24'b0, out_byte}, {24'b0, held});
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
      end
      if (out_valid && !out_ready) chk("bp_rdy", {31'b0, in_ready}, 32'd0);
      hold_pend = out_valid && !out_ready;
      held = out_byte;
      if (out_valid && out_ready) begin
        out_q.push_back(out_byte);
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      if (in_ready) saw_in_ready = 1'b1;
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    chk("done_seen", {31'b0, got_done}, 32'd1);
    tick();
    start = 1'b0; seed = 32'h0; msg_len = '0;
    #1;
    chk("post_busy", {31'b0, busy}, 32'd0);
    chk("post_done", {31'b0, done}, 32'd0);
    tick();
    chk("idle_ld", {31'b0, ld_lfsr}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("ld_count", ld_total - ld_before, 32'd1);
    chk("seed_kept", ld_val, s);
    chk("step_count", env_steps, WARMUP + len);
    chk("out_count", out_q.size(), len);
    if (len > 0) chk("done_lat", done_cyc - last_out_cyc, 32'd1);
  endtask

  logic [7:0] ck;
  logic [7:0] pt[$];
  logic [7:0] ct[$];
  logic [7:0] xr;
  logic [31:0] s_rt;

  initial begin
    // Reset values
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ov", {31'b0, out_valid}, 32'd0);
    chk("rst_ob", {24'b0, out_byte}, 32'd0);
    chk("rst_ld", {31'b0, ld_lfsr}, 32'd0);
    chk("rst_ldval", ld_val, 32'd0);
    chk("rst_step", {31'b0, step_lfsr}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ck", {24'b0, cksum}, 32'd0);
    chk("rst_rdy", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();

    // Seed and warm-up with an empty message, plus starts during WARM and DONE
    in_q.delete();
    run_msg(32'hDEADBEEF, 0, 0, 1'b1, ck);
    chk("len0_rdy", {31'b0, saw_in_ready}, 32'd0);
    chk("len0_ck", {24'b0, ck}, 32'd0);

    // Streaming against a fixed pseudo-random table
    tbl[0] = 8'hA5; tbl[1] = 8'h3C; tbl[2] = 8'h0F; tbl[3] = 8'hF0;
    tbl_mode = 1'b1;
    in_q.delete();
    in_q.push_back(8'h00); in_q.push_back(8'hFF); in_q.push_back(8'h12); in_q.push_back(8'h34);
    run_msg(32'h0BADF00D, 4, 0, 1'b0, ck);
    if (out_q.size() == 4) begin
      chk("strm0", {24'b0, out_q[0]}, 32'hA5);
      chk("strm1", {24'b0, out_q[1]}, 32'hC3);
      chk("strm2", {24'b0, out_q[2]}, 32'h1D);
      chk("strm3", {24'b0, out_q[3]}, 32'hC4);
    end
    chk("strm_consec", last_out_cyc - first_out_cyc, 32'd3);
    tbl_mode = 1'b0;

    // Backpressure on the first output, real LFSR keystream
    in_q.delete();
    for (int i = 0; i < 6; i++) in_q.push_back(8'($urandom));
    run_msg(32'h600DCAFE, 6, 2, 1'b0, ck);
    for (int i = 0; i < out_q.size() && i < 6; i++)
      chk("bp_data", {24'b0, out_q[i]}, {24'b0, in_q[i] ^ key_byte(32'h600DCAFE, WARMUP + i)});

    // Round trip with random valid/ready
    s_rt = $urandom;
    pt.delete();
    for (int i = 0; i < 16; i++) pt.push_back(8'($urandom));
    in_q = pt;
    run_msg(s_rt, 16, 1, 1'b0, ck);
    ct = out_q;
    xr = 8'h0;
    for (int i = 0; i < ct.size(); i++) begin
      xr = xr ^ ct[i];
      if (i < 16) chk("enc_data", {24'b0, ct[i]}, {24'b0, pt[i] ^ key_byte(s_rt, WARMUP + i)});
    end
`ifdef LFSR_STREAM_XOR_CKSUM_EN
    chk("enc_ck", {24'b0, ck}, {24'b0, xr});
`else
    chk("enc_ck", {24'b0, ck}, 32'd0);
`endif
    in_q = ct;
    run_msg(s_rt, 16, 1, 1'b0, ck);
    for (int i = 0; i < out_q.size() && i < 16; i++)
      chk("rt_data", {24'b0, out_q[i]}, {24'b0, pt[i]});

    // Reset mid-RUN with a byte pending at the output
    seed = 32'h13579BDF; msg_len = 8'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < WARMUP; w++) tick();
    in_valid = 1'b1; in_byte = 8'h5A; out_ready = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("pre_rst_ov", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("mrst_ov", {31'b0, out_valid}, 32'd0);
      chk("mrst_busy", {31'b0, busy}, 32'd0);
      chk("mrst_ld", {31'b0, ld_lfsr}, 32'd0);
      chk("mrst_step", {31'b0, step_lfsr}, 32'd0);
      chk("mrst_ck", {24'b0, cksum}, 32'd0);
      chk("mrst_done", {31'b0, done}, 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("after_rst_done", {31'b0, done}, 32'd0);
    chk("after_rst_busy", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
